// File: rtl/sha256_padder_if.sv
// Byte-in / 512-bit-block-out stream bundle for sha256_padder.
// slave is the padder's view, master is the message source / block sink.
interface sha256_padder_if;
    logic [7:0]   s_tdata_i;
    logic         s_tvalid_i;
    logic         s_tlast_i;
    logic         s_tready_o;
    logic [511:0] m_tdata_o;
    logic         m_tvalid_o;
    logic         m_tready_i;
    logic         m_tfirst_o;
    logic         m_tlast_o;

    modport slave (
        input  s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
        output s_tready_o, m_tdata_o, m_tvalid_o, m_tfirst_o, m_tlast_o
    );

    modport master (
        output s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
        input  s_tready_o, m_tdata_o, m_tvalid_o, m_tfirst_o, m_tlast_o
    );
endinterface

// File: rtl/sha256_padder.sv
// Packs a byte message stream into FIPS 180-4 padded 512-bit SHA-256 blocks.
// Optional SHA256_PADDER_ERR_EN adds a sticky err_o flagging byte-counter wrap.
module sha256_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef SHA256_PADDER_ERR_EN
    output logic err_o,
`endif
    sha256_padder_if.slave bus
);
    localparam int unsigned BLK_W = 512;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned POS_W = 9;

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD80,
        S_ZERO,
        S_LEN,
        S_OUT
    } state_e;

    state_e             state_q, state_d;
    state_e             ret_q, ret_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               fin_q, fin_d;
    logic [POS_W-1:0]   pos_c;
    logic               acc_c;

    // Bit offset of byte slot idx; byte 0 lands in [511:504].
    assign pos_c = POS_W'(9'd504 - {idx_q, 3'b000});
    assign acc_c = bus.s_tvalid_i & (state_q == S_DATA);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        fin_d   = fin_q;
        case (state_q)
            S_DATA: begin
                if (acc_c) begin
                    blk_d[pos_c +: 8] = bus.s_tdata_i;
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q + LEN_W'(1);
                    // A full block is flushed before padding begins.
                    if (idx_q == IDX_W'(63)) begin
                        state_d = S_OUT;
                        ret_d   = bus.s_tlast_i ? S_PAD80 : S_DATA;
                    end else if (bus.s_tlast_i) begin
                        state_d = S_PAD80;
                    end
                end
            end
            S_PAD80: begin
                blk_d[pos_c +: 8] = 8'h80;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(63)) begin
                    state_d = S_OUT;
                    ret_d   = S_ZERO;
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                if (idx_q == IDX_W'(56)) begin
                    state_d = S_LEN;
                end else begin
                    blk_d[pos_c +: 8] = 8'h00;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(63)) begin
                        state_d = S_OUT;
                        ret_d   = S_ZERO;
                    end
                end
            end
            S_LEN: begin
                blk_d[63:0] = 64'({cnt_q, 3'b000});
                fin_d       = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.m_tready_i) begin
                    blk_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b0;
                    state_d = ret_q;
                    if (fin_q) begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        fin_d   = 1'b0;
                        state_d = S_DATA;
                    end
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_DATA;
            ret_q   <= S_DATA;
            blk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            fin_q   <= fin_d;
        end
    end

`ifdef SHA256_PADDER_ERR_EN
    logic err_q;

    // Sticky until reset; the wrapped count is still used for padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (acc_c && (&cnt_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    assign bus.s_tready_o = (state_q == S_DATA);
    assign bus.m_tvalid_o = (state_q == S_OUT);
    assign bus.m_tdata_o  = blk_q;
    assign bus.m_tfirst_o = first_q;
    assign bus.m_tlast_o  = fin_q;
endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed table, corner sequences and
// random messages scored against a queue-based FIPS 180-4 padding model.
module tb_sha256_padder;
`ifdef SHA256_PADDER_ERR_EN
    localparam int unsigned TB_LEN_W = 4;
    localparam logic [63:0] L55 = 64'h38;
    localparam logic [63:0] L56 = 64'h40;
    localparam logic [63:0] L64 = 64'h0;
`else
    localparam int unsigned TB_LEN_W = 32;
    localparam logic [63:0] L55 = 64'h1B8;
    localparam logic [63:0] L56 = 64'h1C0;
    localparam logic [63:0] L64 = 64'h200;
`endif

    typedef logic [7:0] byte_t;
    typedef byte_t bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;
    typedef struct {
        int           len;
        byte_t        base;
        byte_t        step;
        int           nblk;
        logic [63:0]  len_fld;
        logic [31:0]  top32;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
`ifdef SHA256_PADDER_ERR_EN
    logic err_o;
`endif

    always #5 clk = ~clk;

    sha256_padder_if bus ();

    sha256_padder #(.LEN_W(TB_LEN_W)) dut (
        .clk  (clk),
`ifdef SHA256_PADDER_ERR_EN
        .err_o(err_o),
`endif
        .rst  (rst),
        .bus  (bus)
    );

    blk_t exp_q[$];
    blk_t log_q[$];
    blk_t held, cur, e, abc_blk;
    bit   held_v    = 1'b0;
    bit   post_last = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   rdy_mode  = 2;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic model_push(input bq_t m);
        bq_t         p;
        blk_t        b;
        logic [63:0] bl;
        int          nb;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(m.size()) % (64'd1 << TB_LEN_W);
        bl = bl * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nb = p.size() / 64;
        for (int i = 0; i < nb; i++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[i*64+j];
            b.first = (i == 0);
            b.last  = (i == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input byte_t b, input bit last);
        int t = 0;
        bus.s_tdata_i  = b;
        bus.s_tvalid_i = 1'b1;
        bus.s_tlast_i  = last;
        @(negedge clk);
        while (!bus.s_tready_o && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 512'(t >= 5000), 512'(1'b0));
        @(posedge clk);
        #1;
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
    endtask

    task automatic send_msg(input bq_t m, input int max_gap);
        for (int i = 0; i < m.size(); i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(m[i], i == m.size() - 1);
            if (i % 64 == 63) begin
                @(negedge clk);
                chk("data_blk_latency", 512'(bus.m_tvalid_o), 512'(1'b1));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int max);
        int t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 512'(exp_q.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.m_tready_i = ($urandom_range(0, 3) != 0);
            1:       bus.m_tready_i = 1'b0;
            default: bus.m_tready_i = 1'b1;
        endcase
    end

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            held_v    = 1'b0;
            post_last = 1'b0;
        end else begin
            if (post_last) begin
                chk("b2b_s_tready", 512'(bus.s_tready_o), 512'(1'b1));
                post_last = 1'b0;
            end
            if (bus.m_tvalid_o) begin
                cur.data  = bus.m_tdata_o;
                cur.first = bus.m_tfirst_o;
                cur.last  = bus.m_tlast_o;
                chk("s_tready_during_out", 512'(bus.s_tready_o), 512'(1'b0));
                if (held_v) begin
                    chk("hold_data", cur.data, held.data);
                    chk("hold_first", 512'(cur.first), 512'(held.first));
                    chk("hold_last", 512'(cur.last), 512'(held.last));
                end
                if (bus.m_tready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_block: got %0h expected none", cur.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", cur.data, e.data);
                        chk("blk_first", 512'(cur.first), 512'(e.first));
                        chk("blk_last", 512'(cur.last), 512'(e.last));
                    end
                    log_q.push_back(cur);
                    post_last = cur.last;
                    held_v    = 1'b0;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t  vt[4];
        bq_t   msg;
        blk_t  lb;
        blk_t  ref_b;
        int    n0;
        int    t;
        int    blens[9];

        vt[0] = '{3,  8'h61, 8'h01, 1, 64'h18, 32'h61626380};
        vt[1] = '{55, 8'h00, 8'h00, 1, L55,    32'h00000000};
        vt[2] = '{56, 8'hFF, 8'h00, 2, L56,    32'hFFFFFFFF};
        vt[3] = '{64, 8'h00, 8'h01, 2, L64,    32'h00010203};
        blens = '{1, 55, 56, 63, 64, 65, 119, 120, 128};

        bus.s_tdata_i  = 8'h00;
        bus.s_tvalid_i = 1'b0;
        bus.s_tlast_i  = 1'b0;
        bus.m_tready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_s_tready", 512'(bus.s_tready_o), 512'(1'b1));
        chk("rst_m_tvalid", 512'(bus.m_tvalid_o), 512'(1'b0));
        chk("rst_m_tdata", bus.m_tdata_o, 512'(0));
        chk("rst_m_tfirst", 512'(bus.m_tfirst_o), 512'(1'b1));
        chk("rst_m_tlast", 512'(bus.m_tlast_o), 512'(1'b0));
`ifdef SHA256_PADDER_ERR_EN
        chk("rst_err", 512'(err_o), 512'(1'b0));
`endif
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expectations.
        rdy_mode = 0;
        for (int v = 0; v < 4; v++) begin
            msg = {};
            for (int i = 0; i < vt[v].len; i++) msg.push_back(8'(vt[v].base + vt[v].step * i));
            n0 = log_q.size();
            model_push(msg);
            send_msg(msg, 0);
            wait_drain(2000);
            chk("tbl_nblk", 512'(log_q.size() - n0), 512'(vt[v].nblk));
            if (log_q.size() > n0) begin
                lb = log_q[log_q.size() - 1];
                chk("tbl_top32", 512'(log_q[n0].data[511:480]), 512'(vt[v].top32));
                chk("tbl_first", 512'(log_q[n0].first), 512'(1'b1));
                chk("tbl_last", 512'(lb.last), 512'(1'b1));
                chk("tbl_len_fld", 512'(lb.data[63:0]), 512'(vt[v].len_fld));
                if (v == 0) abc_blk = log_q[n0];
            end
        end

        // Backpressure during "abc": output holds and exactly one block moves on release.
        rdy_mode = 1;
        idle(2);
        msg = '{8'h61, 8'h62, 8'h63};
        model_push(msg);
        send_msg(msg, 0);
        t = 0;
        @(negedge clk);
        while (!bus.m_tvalid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_timeout", 512'(bus.m_tvalid_o), 512'(1'b1));
        ref_b.data  = bus.m_tdata_o;
        ref_b.first = bus.m_tfirst_o;
        ref_b.last  = bus.m_tlast_o;
        n0 = log_q.size();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_data", bus.m_tdata_o, ref_b.data);
            chk("bp_flags", 512'({bus.m_tfirst_o, bus.m_tlast_o}), 512'(2'b11));
            chk("bp_s_tready", 512'(bus.s_tready_o), 512'(1'b0));
        end
        chk("bp_no_xfer", 512'(log_q.size()), 512'(n0));
        rdy_mode = 2;
        idle(6);
        @(negedge clk);
        chk("bp_one_xfer", 512'(log_q.size()), 512'(n0 + 1));
        chk("bp_valid_drop", 512'(bus.m_tvalid_o), 512'(1'b0));
        @(posedge clk);
        #1;

        // Reset mid-message discards 20 bytes; "abc" afterwards must match the clean case.
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_tready", 512'(bus.s_tready_o), 512'(1'b1));
        chk("mid_rst_first", 512'(bus.m_tfirst_o), 512'(1'b1));
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        n0 = log_q.size();
        model_push(msg);
        send_msg(msg, 0);
        wait_drain(2000);
        if (log_q.size() > n0) begin
            lb = log_q[n0];
            chk("rst_abc_data", lb.data, abc_blk.data);
            chk("rst_abc_flags", 512'({lb.first, lb.last}), 512'(2'b11));
        end

`ifdef SHA256_PADDER_ERR_EN
        // 16 bytes through a 4-bit counter: wrap flags err and zeroes the length.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        msg = {};
        for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
        model_push(msg);
        for (int i = 0; i < 15; i++) send_byte(msg[i], 1'b0);
        @(negedge clk);
        chk("err_before_wrap", 512'(err_o), 512'(1'b0));
        @(posedge clk);
        #1;
        send_byte(msg[15], 1'b1);
        @(negedge clk);
        chk("err_after_wrap", 512'(err_o), 512'(1'b1));
        @(posedge clk);
        #1;
        wait_drain(2000);
        chk("err_len_fld", 512'(log_q[log_q.size() - 1].data[63:0]), 512'(0));
`endif

        // Random messages, back to back, with input gaps and random output stalls.
        rdy_mode = 0;
        for (int r = 0; r < 24; r++) begin
            int len;
            len = (r < 9) ? blens[r] : int'($urandom_range(1, 150));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            model_push(msg);
            send_msg(msg, r % 3);
        end
        wait_drain(20000);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream stage of `sha256_stream`: converts a byte-wide message stream into padded 512-bit SHA-256 blocks.
- Appends the 0x80 marker, zero fill and the 64-bit big-endian bit length per FIPS 180-4.
- Emits blocks on a valid/ready stream.
- `m_tfirst_o` drives `sha256_stream.s_tlast_i`, which that stage treats as start-of-message (core init). `m_tlast_o` marks the final block of a message.

## Interface
- `LEN_W`, default 32: width of the internal message byte counter. Bit length is `{cnt, 3'b000}`, zero-extended to 64 bits. Legal range 4..61.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_tdata_i` in 8: message byte.
- `s_tvalid_i` in 1: input byte valid.
- `s_tlast_i` in 1: this byte is the final byte of the message.
- `s_tready_o` out 1: byte accepted when `s_tvalid_i & s_tready_o`.
- `m_tdata_o` out 512: block. First message byte sits in `[511:504]`.
- `m_tvalid_o` out 1: block valid.
- `m_tready_i` in 1: downstream accepts the block.
- `m_tfirst_o` out 1: block is the first block of a message.
- `m_tlast_o` out 1: block is the last block of a message.
- `err_o` out 1: only present with `SHA256_PADDER_ERR_EN`.

## Operation
- FSM states: `S_DATA`, `S_PAD80`, `S_ZERO`, `S_LEN`, `S_OUT`.
- Registers: `buf[511:0]`, `idx[5:0]`, `cnt[LEN_W-1:0]`, `first` flag, `final` flag, `ret_state`.
- `S_DATA`
  - `s_tready_o=1`.
  - On each accepted byte: `buf[511-8*idx -: 8] <= byte`, `idx++`, `cnt++`.
  - If `s_tlast_i`, the next state is `S_PAD80`; a block-full condition is resolved first.
  - If `idx==63` on accept: go to `S_OUT` with `ret_state = s_tlast_i ? S_PAD80 : S_DATA`.
- `S_PAD80`: write 0x80 at `idx`, `idx++`.
  - Entered at `idx==63`: go to `S_OUT`, `ret_state=S_ZERO`.
  - Otherwise: go to `S_ZERO`.
- `S_ZERO`: write 0x00 at `idx`, one byte per cycle, `idx++`.
  - At `idx==56` with no write: go to `S_LEN`.
  - At `idx==63` with a write: go to `S_OUT`, `ret_state=S_ZERO`.
- `S_LEN`: in one cycle, `buf[63:0] <= {cnt,3'b000}` zero-extended, `final<=1`, go to `S_OUT`.
- `S_OUT`
  - `m_tvalid_o=1`, `m_tdata_o=buf`, `m_tfirst_o=first`, `m_tlast_o=final`.
  - On `m_tready_i`: `buf<=0`, `idx<=0`, `first<=0`, go to `ret_state`.
  - If `final`: also `cnt<=0`, `first<=1`, `final<=0`, go to `S_DATA`.
- `s_tready_o=0` in every state except `S_DATA`.
- Bytes are never dropped and never reordered.
- Zero-length messages are unsupported. Every message carries at least one byte, the one with `s_tlast_i`.
- `m_tfirst_o` and `m_tlast_o` are both high on a single-block message.

## Timing
- Reset values: `s_tready_o=1`, `m_tvalid_o=0`, `m_tdata_o=0`, `m_tfirst_o=1`, `m_tlast_o=0`, `err_o=0`. FSM in `S_DATA`, `idx=0`, `cnt=0`.
- Reset mid-message: the partial block and the count are discarded. The next accepted byte starts a new message with `first=1`.
- Data-block latency: byte 63 accepted at cycle N gives `m_tvalid_o` at N+1.
- Final block latency: `S_PAD80` takes 1 cycle, `S_ZERO` takes `56-idx` cycles, `S_LEN` takes 1 cycle, then `S_OUT`.
- Output handshake
  - While `m_tvalid_o=1` and `m_tready_i=0`, `m_tdata_o`, `m_tfirst_o` and `m_tlast_o` hold stable.
  - `m_tvalid_o` drops the cycle after the handshake.
- Message-length boundaries:
  - ≤55 bytes within the last block: 1 padded block.
  - 56..63 bytes within the last block: an extra all-pad block.
  - Exactly 64k bytes: an extra block starting with 0x80.
- Back-to-back messages: after the final handshake, `s_tready_o=1` the next cycle.

## Configuration
- `SHA256_PADDER_ERR_EN` defined
  - `err_o` exists.
  - It sets sticky when an accepted byte wraps `cnt` from all-ones to 0.
  - It clears on `rst` only.
  - Padding still uses the wrapped count.
- `SHA256_PADDER_ERR_EN` undefined: no `err_o` port and no overflow logic; `cnt` wraps silently.

## Test plan
- "abc" (0x61,0x62,0x63; last on 0x63) -> one block.
  - `m_tdata_o = 0x61626380` followed by zeros, with `[63:0]=0x18`.
  - `first=1`, `last=1`.
- 55 bytes of 0x00 -> one block: byte 55 is 0x80, `[63:0]=0x1B8`, `first=last=1`.
- 56 bytes of 0xFF -> two blocks.
  - Block 0: 56×0xFF, 0x80, 7×0x00, `first=1`, `last=0`.
  - Block 1: zeros except `[63:0]=0x1C0`, `first=0`, `last=1`.
- 64 bytes 0x00..0x3F -> two blocks.
  - Block 0 is the data verbatim.
  - Block 1 is 0x80 in `[511:504]`, then zeros, with `[63:0]=0x200`.
- Backpressure: `m_tready_i=0` for 10 cycles during "abc".
  - `m_tdata_o` and the flags are stable.
  - `s_tready_o=0` throughout.
  - Exactly one block is transferred on release.
- Reset after 20 bytes, then "abc" -> output identical to the "abc" case.
- With `SHA256_PADDER_ERR_EN` and `LEN_W=4`: 16-byte message -> `err_o=1` after byte 16, `[63:0]=0x0`.
